// File: rtl/wb_sram_1024x32_pkg.sv
// Shared definitions for the Wishbone 1024x32 SRAM slave.
//   AW, DW, NBYTES : word-address width, data width, byte lanes
//   wb_state_e     : handshake controller states
package wb_sram_1024x32_pkg;

    localparam int AW     = 10;
    localparam int DW     = 32;
    localparam int NBYTES = DW / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/sram_core_1024x32.sv
// Synchronous single-port 1024x32 RAM with byte-write enables.
//   CLK     : clock, rising edge
//   EN      : access enable for this edge
//   R_WB    : 1 = read, 0 = write
//   BEN     : byte-lane write enables, bit n covers DI/array bits [8n+7:8n]
//   AD      : word address
//   DI      : write data
//   DO      : registered read data; updates only on an enabled read
// The array and DO have no reset; contents are undefined until written.
module sram_core_1024x32
    import wb_sram_1024x32_pkg::*;
(
    input  logic              CLK,
    input  logic              EN,
    input  logic              R_WB,
    input  logic [NBYTES-1:0] BEN,
    input  logic [AW-1:0]     AD,
    input  logic [DW-1:0]     DI,
    output logic [DW-1:0]     DO
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge CLK) begin
        if (EN) begin
            if (R_WB) begin
                DO <= mem[AD];
            end else begin
                for (int n = 0; n < NBYTES; n++) begin
                    if (BEN[n]) begin
                        mem[AD][8*n +: 8] <= DI[8*n +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/wb_sram_1024x32.sv
// Wishbone classic (B3) slave around a 1024x32 byte-writable SRAM.
//   clk, rst_n : clock (rising edge), async active-low reset
//   wbs_stb_i, wbs_cyc_i, wbs_we_i : Wishbone strobe / cycle / write
//   wbs_sel_i  : byte-lane enables for writes (ignored on reads)
//   wbs_dat_i  : write data
//   wbs_adr_i  : word address, only [9:0] decoded (upper bits alias)
//   wbs_ack_o  : one-cycle registered acknowledge
//   wbs_dat_o  : read data, valid with ack, held until the next read
//
// state   | meaning
// ST_IDLE | waiting for cyc & stb; ack low
// ST_ACK  | ack high for this cycle; always returns to ST_IDLE
module wb_sram_1024x32
    import wb_sram_1024x32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [NBYTES-1:0] wbs_sel_i,
    input  logic [DW-1:0]     wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [DW-1:0]     wbs_dat_o
);

    wb_state_e     state_q;
    logic          rd_valid_q;
    logic          wb_req;
    logic [DW-1:0] core_do;
    logic          unused_adr_hi;

    // Masking on ack keeps back-to-back holds of stb from re-triggering in the ack cycle.
    assign wb_req        = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign unused_adr_hi = ^wbs_adr_i[31:AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wbs_ack_o  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wb_req) begin
                        state_q   <= ST_ACK;
                        wbs_ack_o <= 1'b1;
                        if (!wbs_we_i) begin
                            rd_valid_q <= 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    state_q   <= ST_IDLE;
                    wbs_ack_o <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    wbs_ack_o <= 1'b0;
                end
            endcase
        end
    end

    sram_core_1024x32 u_core (
        .CLK  (clk),
        .EN   (wb_req),
        .R_WB (~wbs_we_i),
        .BEN  (wbs_sel_i),
        .AD   (wbs_adr_i[AW-1:0]),
        .DI   (wbs_dat_i),
        .DO   (core_do)
    );

    // The core output register has no reset; until the first read after
    // reset it is gated to zero so dat_o comes out of reset cleared.
    assign wbs_dat_o = rd_valid_q ? core_do : '0;

endmodule

// File: tb/tb_wb_sram_1024x32.sv
// Directed bench for wb_sram_1024x32: reference memory model plus a
// queue of expected read data, compared when ack is seen.
module tb_wb_sram_1024x32;

    logic        clk;
    logic        rst_n;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [1024];
    logic [31:0] sb [$];

    wb_sram_1024x32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        for (int n = 0; n < 4; n++) begin
            if (sel[n]) model[adr[9:0]][8*n +: 8] = dat[8*n +: 8];
        end
    endtask

    // Entered and left on a falling edge. Returns with stb/cyc dropped.
    task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat);
        int          waited;
        logic        got;
        logic [31:0] held;
        logic [31:0] exp;
        held = wbs_dat_o;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_sel_i = sel;
        wbs_dat_i = dat;
        if (we) model_write(adr, sel, dat);
        else    sb.push_back(model[adr[9:0]]);
        got    = 1'b0;
        waited = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            waited = i;
            if (wbs_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_ack_latency"}, 32'(got ? waited : 99), 32'd0);
        if (!we && got) begin
            exp = sb.pop_front();
            chk({tag, "_rdata"}, wbs_dat_o, exp);
            #4;
            chk({tag, "_rdata_stable"}, wbs_dat_o, exp);
        end else if (we && got) begin
            chk({tag, "_dat_hold"}, wbs_dat_o, held);
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_pulse"}, {31'd0, wbs_ack_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] exp;
        logic [9:0]  a;

        rst_n     = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_sel_i = 4'b0000;
        wbs_adr_i = 32'h5;
        wbs_dat_i = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);

        // Request pending across reset release: sel=0 write, acks, changes nothing.
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_ack", {31'd0, wbs_ack_o}, 32'd1);
        chk("first_dat", wbs_dat_o, 32'd0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(negedge clk);
        chk("first_ack_drop", {31'd0, wbs_ack_o}, 32'd0);

        xfer("wr_full", 1'b1, 32'h005, 4'hF, 32'hDEADBEEF);
        xfer("rd_full", 1'b0, 32'h005, 4'h0, 32'h0);

        xfer("wr_lane_a", 1'b1, 32'h3FF, 4'hF, 32'h11223344);
        xfer("wr_lane_b", 1'b1, 32'h3FF, 4'b0101, 32'hAABBCCDD);
        xfer("rd_lane", 1'b0, 32'h3FF, 4'hF, 32'h0);
        chk("lane_const", model[10'h3FF], 32'h11BB33DD);

        xfer("wr_sel0", 1'b1, 32'h3FF, 4'b0000, 32'hFFFFFFFF);
        xfer("rd_sel0", 1'b0, 32'h3FF, 4'hF, 32'h0);

        xfer("wr_alias", 1'b1, 32'h00000400, 4'hF, 32'hCAFEF00D);
        xfer("wr_w1", 1'b1, 32'h1, 4'hF, 32'h01010101);
        xfer("wr_w20", 1'b1, 32'h14, 4'hF, 32'h20202020);
        xfer("rd_w0", 1'b0, 32'h0, 4'hF, 32'h0);
        xfer("rd_w1", 1'b0, 32'hFFFFFC01, 4'hF, 32'h0);
        xfer("rd_w20", 1'b0, 32'h14, 4'hF, 32'h0);

        // stb/cyc held on a read for six cycles: ack in alternate cycles.
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = 32'h005;
        exp = 32'hDEADBEEF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("hold_ack_%0d", i), {31'd0, wbs_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) chk($sformatf("hold_dat_%0d", i), wbs_dat_o, exp);
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;

        // Strobe without cycle: no ack and no write.
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h005;
        wbs_dat_i = 32'h0BADF00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("nocyc_ack_%0d", i), {31'd0, wbs_ack_o}, 32'd0);
        end
        wbs_stb_i = 1'b0;
        @(negedge clk);
        xfer("rd_nocyc", 1'b0, 32'h005, 4'hF, 32'h0);

        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < 20; k++) begin
                a = {c[4:0], k[4:0]};
                v = 32'(c * 32 + k);
                xfer("sweep_wr", 1'b1, {22'd0, a}, 4'hF, v);
            end
        end
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < 20; k++) begin
                a = {c[4:0], k[4:0]};
                xfer("sweep_rd", 1'b0, {22'd0, a}, 4'hF, 32'h0);
            end
        end
        chk("sweep_const", model[{5'd19, 5'd19}], 32'd627);

        // Async reset clears dat_o without a clock edge.
        xfer("rd_pre_rst", 1'b0, 32'h3FF, 4'hF, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dat", wbs_dat_o, 32'd0);
        chk("async_rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer("rd_post_rst", 1'b0, 32'h3FF, 4'hF, 32'h0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
